nic_host_agent: RTL and testbench
=================================

Name: nic_host_agent

Overview:
- Processor-side agent for one cardinal_nic node; one instance per node (4 total), each driving one NIC's addr_nic/d_in/nicEn/nicWrEn bus and reading its d_out.
- Converts a local valid/ready packet source and sink into NIC register polling and transfer.
- Alternates fairly between sending to and receiving from the ring.
- Keeps wrap-around transfer counters for bench and system statistics.

Parameters:
- DATA_W, 64, packet / NIC data width.
- CNT_W, 16, width of the tx_cnt and rx_cnt statistic counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- tx_valid  in  1  local packet offered for injection.
- tx_data  in  DATA_W  packet to inject; held stable while tx_valid=1 and tx_ready=0.
- tx_ready  out  1  one-cycle pulse; packet is consumed on this cycle.
- rx_valid  out  1  received packet held on rx_data.
- rx_data  out  DATA_W  received packet.
- rx_ready  in  1  local sink accepts rx_data when rx_valid=1.
- addr_nic  out  2  NIC register address.
- d_in  out  DATA_W  NIC write data.
- nicEn  out  1  NIC access enable.
- nicWrEn  out  1  NIC write enable (qualified by nicEn).
- d_out  in  DATA_W  NIC read data; valid the cycle after a read is issued.
- tx_cnt  out  CNT_W  packets written to the NIC.
- rx_cnt  out  CNT_W  packets read from the NIC.

Behaviour:
- NIC register map:
  - 00 = input buffer (read).
  - 01 = input status (read); d_out[0]=1 means a packet is present.
  - 10 = output buffer (write).
  - 11 = output status (read); d_out[0]=1 means full.
- Read protocol: issue with nicEn=1, nicWrEn=0; sample d_out on the next cycle.
- Write protocol: nicEn=1, nicWrEn=1; the write takes effect at that clock edge.
- At most one NIC access per cycle.
- addr_nic, nicEn, nicWrEn and d_in are decoded combinationally from state. Outside access states: nicEn=0, nicWrEn=0, addr_nic=0, d_in=0.
- FSM states: IDLE, TX_STAT, TX_CHK, TX_WR, RX_STAT, RX_CHK, RX_RD, RX_CAP. A 1-bit turn register arbitrates; reset value = TX.
- IDLE transitions:
  - to TX_STAT if tx_valid && (turn==TX || rx_valid);
  - else to RX_STAT if !rx_valid;
  - else stay in IDLE.
- TX_STAT: read addr 11 → TX_CHK.
- TX_CHK: if d_out[0]=0 → TX_WR; else → IDLE. Either way turn:=RX.
- TX_WR: write addr 10 with d_in=tx_data; tx_ready=1; tx_cnt+=1 → IDLE.
- RX_STAT: read addr 01 → RX_CHK.
- RX_CHK: if d_out[0]=1 → RX_RD; else → IDLE. Either way turn:=TX.
- RX_RD: read addr 00 → RX_CAP.
- RX_CAP: rx_data:=d_out, rx_valid:=1, rx_cnt+=1 → IDLE.
- rx_valid stays high until the cycle rx_valid && rx_ready, then clears on the next edge; rx_data holds its value.
- No RX polling while rx_valid=1, so a packet is never overwritten.
- Minimum latency:
  - tx_valid seen in IDLE at cycle 0 → tx_ready at cycle 3.
  - RX: RX_STAT at cycle 1 → rx_valid high at cycle 5.
- Simultaneous TX and RX demand: strict alternation by turn. A rejected poll (output full, input empty) still flips turn, so neither side starves.
- tx_valid dropped mid-sequence is a protocol violation and its behaviour is undefined. The bench keeps tx_valid asserted until tx_ready.
- Counters wrap modulo 2^CNT_W.
- Reset (reset=0 at a clock edge):
  - state:=IDLE, turn:=TX, rx_valid:=0, rx_data:=0, tx_cnt:=0, rx_cnt:=0.
  - NIC outputs are inactive during reset cycles.
  - Any in-flight read is discarded; no partial write is issued.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, tx_valid=0, NIC input status=0 → agent polls addr 01 repeatedly; nicWrEn never 1; all counters 0; rx_valid=0.
- Single send: tx_valid=1, tx_data=64'hA5A5_0000_0000_0001, output status=0 → nicEn=1, nicWrEn=1, addr=10, d_in=A5A5...01 in cycle 3; tx_ready pulses once; tx_cnt=1.
- Output full backpressure: output status=1 for 5 polls, then 0 → no write while full; exactly one write after status clears; tx_ready pulses once.
- Receive with stall: input status=1, buffer=64'h8000_0000_0000_00FF, rx_ready=0 for 10 cycles → rx_valid=1 with that data; no addr 00/01 reads while held; rx_ready=1 → rx_valid=0 next cycle; rx_cnt=1.
- Contention: tx_valid continuously high, both statuses permit transfer → TX_WR and RX_CAP alternate; after 8 transfers tx_cnt=4, rx_cnt=4.
- Reset mid-op: assert reset during RX_RD → no rx_valid afterwards; rx_cnt=0; after release the first access is an addr 11 read if tx_valid=1.

Source files
------------

// File: rtl/nic_host_agent.sv
// Processor-side agent for one NIC node: polls status registers and moves packets between local valid/ready ports and the NIC.
// TX: tx_valid in IDLE to tx_ready in 3 cycles. RX: 4 cycles poll to capture. A held rx_valid blocks further RX polling.
module nic_host_agent #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic [1:0]        addr_nic,
    output logic [DATA_W-1:0] d_in,
    output logic              nicEn,
    output logic              nicWrEn,
    input  logic [DATA_W-1:0] d_out,
    output logic [CNT_W-1:0]  tx_cnt,
    output logic [CNT_W-1:0]  rx_cnt
);

    typedef enum logic [2:0] {
        IDLE, TX_STAT, TX_CHK, TX_WR, RX_STAT, RX_CHK, RX_RD, RX_CAP
    } state_t;

    localparam logic TURN_TX = 1'b0;
    localparam logic TURN_RX = 1'b1;

    localparam logic [1:0] A_IN_BUF   = 2'b00;
    localparam logic [1:0] A_IN_STAT  = 2'b01;
    localparam logic [1:0] A_OUT_BUF  = 2'b10;
    localparam logic [1:0] A_OUT_STAT = 2'b11;

    state_t state, state_nxt;
    logic   turn, turn_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            turn  <= TURN_TX;
        end else begin
            state <= state_nxt;
            turn  <= turn_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
        end else begin
            // RX_CAP is only reachable with rx_valid low, so set and clear never collide
            if (state == RX_CAP) begin
                rx_valid <= 1'b1;
                rx_data  <= d_out;
                rx_cnt   <= rx_cnt + CNT_W'(1);
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (state == TX_WR) begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        turn_nxt  = turn;
        nicEn     = 1'b0;
        nicWrEn   = 1'b0;
        addr_nic  = 2'b00;
        d_in      = '0;
        tx_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_valid && (turn == TURN_TX || rx_valid)) begin
                    state_nxt = TX_STAT;
                end else if (!rx_valid) begin
                    state_nxt = RX_STAT;
                end
            end
            TX_STAT: begin
                nicEn     = 1'b1;
                addr_nic  = A_OUT_STAT;
                state_nxt = TX_CHK;
            end
            TX_CHK: begin
                turn_nxt  = TURN_RX;
                state_nxt = d_out[0] ? IDLE : TX_WR;
            end
            TX_WR: begin
                nicEn     = 1'b1;
                nicWrEn   = 1'b1;
                addr_nic  = A_OUT_BUF;
                d_in      = tx_data;
                tx_ready  = 1'b1;
                state_nxt = IDLE;
            end
            RX_STAT: begin
                nicEn     = 1'b1;
                addr_nic  = A_IN_STAT;
                state_nxt = RX_CHK;
            end
            RX_CHK: begin
                turn_nxt  = TURN_TX;
                state_nxt = d_out[0] ? RX_RD : IDLE;
            end
            RX_RD: begin
                nicEn     = 1'b1;
                addr_nic  = A_IN_BUF;
                state_nxt = RX_CAP;
            end
            RX_CAP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Keep the NIC bus quiet while reset is held, whatever state the register still shows
        if (!reset) begin
            nicEn    = 1'b0;
            nicWrEn  = 1'b0;
            addr_nic = 2'b00;
            d_in     = '0;
            tx_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_nic_host_agent.sv
// Directed bench for nic_host_agent with a behavioural NIC register model.
module tb_nic_host_agent;
    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic [1:0]    addr_nic;
    logic [DW-1:0] d_in;
    logic          nicEn;
    logic          nicWrEn;
    logic [DW-1:0] d_out = '0;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;

    always #5 clk = ~clk;

    nic_host_agent #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .addr_nic(addr_nic), .d_in(d_in), .nicEn(nicEn), .nicWrEn(nicWrEn),
        .d_out(d_out), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
    );

    // NIC model: output status reads full until rd11_n reaches full_until
    logic          in_present;
    logic [DW-1:0] in_buf;
    int            full_until;
    int            wr_n = 0, rd00_n = 0, rd01_n = 0, rd11_n = 0, txr_n = 0, wr_full_n = 0;
    logic [DW-1:0] last_din = '0;
    bit            ev_log[$];

    always @(posedge clk) begin
        if (nicEn && !nicWrEn) begin
            case (addr_nic)
                2'b00: begin
                    d_out  <= in_buf;
                    rd00_n <= rd00_n + 1;
                    ev_log.push_back(1'b0);
                end
                2'b01: begin
                    d_out  <= DW'(in_present);
                    rd01_n <= rd01_n + 1;
                end
                2'b11: begin
                    d_out  <= DW'(rd11_n < full_until);
                    rd11_n <= rd11_n + 1;
                end
                default: d_out <= '0;
            endcase
        end
        if (nicEn && nicWrEn) begin
            wr_n     <= wr_n + 1;
            last_din <= d_in;
            if (addr_nic == 2'b10) ev_log.push_back(1'b1);
            if (rd11_n < full_until) wr_full_n <= wr_full_n + 1;
        end
        if (tx_ready) txr_n <= txr_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for the tx_ready pulse, then withdraws tx_valid once the packet is consumed
    task automatic wait_txr(input string tag, input int budget);
        int k;
        k = 0;
        while (!tx_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(tx_ready), 64'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    int b0, b1, b2, b3, b4, k, ev0;

    initial begin
        reset      = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        rx_ready   = 1'b0;
        in_present = 1'b0;
        in_buf     = '0;
        full_until = 0;

        // Reset then idle polling
        repeat (3) @(negedge clk);
        chk("rst_nicen", 64'(nicEn), 64'd0);
        chk("rst_wren", 64'(nicWrEn), 64'd0);
        reset = 1'b1;
        chk("rst_txcnt", 64'(tx_cnt), 64'd0);
        chk("rst_rxcnt", 64'(rx_cnt), 64'd0);
        chk("rst_rxvalid", 64'(rx_valid), 64'd0);
        b0 = rd01_n; b1 = wr_n;
        cycles(21);
        chk("idle_poll01", 64'(rd01_n - b0), 64'd7);
        chk("idle_nowrite", 64'(wr_n - b1), 64'd0);
        chk("idle_rxvalid", 64'(rx_valid), 64'd0);

        // Single send with exact latency from reset release
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 64'hA5A5_0000_0000_0001;
        cycles(2);
        reset = 1'b1;
        b0 = wr_n; b1 = txr_n;
        cycles(2);
        chk("send_early", 64'(tx_ready), 64'd0);
        @(negedge clk);
        chk("send_en", 64'(nicEn), 64'd1);
        chk("send_wren", 64'(nicWrEn), 64'd1);
        chk("send_addr", 64'(addr_nic), 64'd2);
        chk("send_din", d_in, 64'hA5A5_0000_0000_0001);
        chk("send_ready", 64'(tx_ready), 64'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        cycles(5);
        chk("send_pulses", 64'(txr_n - b1), 64'd1);
        chk("send_writes", 64'(wr_n - b0), 64'd1);
        chk("send_txcnt", 64'(tx_cnt), 64'd1);

        // Output-full backpressure: five full polls, then clear
        b0 = wr_n; b1 = txr_n; b2 = wr_full_n; b3 = rd11_n;
        full_until = rd11_n + 5;
        tx_data    = 64'h1234_5678_9ABC_DEF0;
        tx_valid   = 1'b1;
        wait_txr("bp_ready", 200);
        cycles(5);
        chk("bp_writes", 64'(wr_n - b0), 64'd1);
        chk("bp_pulses", 64'(txr_n - b1), 64'd1);
        chk("bp_wr_full", 64'(wr_full_n - b2), 64'd0);
        chk("bp_polls", 64'(rd11_n - b3), 64'd6);
        chk("bp_din", last_din, 64'h1234_5678_9ABC_DEF0);
        chk("bp_txcnt", 64'(tx_cnt), 64'd2);

        // Receive with sink stall
        in_buf     = 64'h8000_0000_0000_00FF;
        in_present = 1'b1;
        k = 0;
        while (!rx_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rx_valid_set", 64'(rx_valid), 64'd1);
        chk("rx_data", rx_data, 64'h8000_0000_0000_00FF);
        b0 = rd00_n; b1 = rd01_n;
        cycles(10);
        chk("rx_held", 64'(rx_valid), 64'd1);
        chk("rx_no_rd00", 64'(rd00_n - b0), 64'd0);
        chk("rx_no_rd01", 64'(rd01_n - b1), 64'd0);
        rx_ready   = 1'b1;
        in_present = 1'b0;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_cleared", 64'(rx_valid), 64'd0);
        chk("rx_data_hold", rx_data, 64'h8000_0000_0000_00FF);
        chk("rx_cnt1", 64'(rx_cnt), 64'd1);

        // Contention: both sides always ready, strict alternation from a fresh reset
        reset      = 1'b0;
        tx_valid   = 1'b1;
        tx_data    = 64'h0000_0000_CAFE_0005;
        in_buf     = 64'h0000_0000_BEEF_0007;
        in_present = 1'b1;
        rx_ready   = 1'b1;
        cycles(2);
        ev0   = ev_log.size();
        reset = 1'b1;
        k = 0;
        while ((ev_log.size() - ev0) < 8 && k < 300) begin
            @(negedge clk);
            k++;
        end
        tx_valid   = 1'b0;
        in_present = 1'b0;
        chk("cont_events", 64'(ev_log.size() - ev0), 64'd8);
        cycles(10);
        rx_ready = 1'b0;
        chk("cont_txcnt", 64'(tx_cnt), 64'd4);
        chk("cont_rxcnt", 64'(rx_cnt), 64'd4);
        for (int i = 0; i < 8; i++) begin
            if (ev0 + i < ev_log.size())
                chk($sformatf("cont_order%0d", i), 64'(ev_log[ev0 + i]), 64'((i % 2) == 0));
        end

        // Reset while the input buffer read is on the bus
        in_buf     = 64'h0000_0000_DEAD_0009;
        in_present = 1'b1;
        k = 0;
        while (!(nicEn && !nicWrEn && addr_nic == 2'b00) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_found_rd", 64'(nicEn && !nicWrEn && addr_nic == 2'b00), 64'd1);
        reset      = 1'b0;
        tx_valid   = 1'b1;
        tx_data    = 64'h0000_0000_0000_0042;
        in_present = 1'b0;
        #1;
        chk("mid_quiet", 64'(nicEn), 64'd0);
        cycles(2);
        reset = 1'b1;
        chk("mid_rxvalid", 64'(rx_valid), 64'd0);
        chk("mid_rxcnt", 64'(rx_cnt), 64'd0);
        k = 0;
        while (!nicEn && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("mid_first_en", 64'(nicEn), 64'd1);
        chk("mid_first_addr", 64'(addr_nic), 64'd3);
        chk("mid_first_rd", 64'(nicWrEn), 64'd0);
        wait_txr("mid_ready", 50);
        cycles(5);
        chk("mid_rxvalid_end", 64'(rx_valid), 64'd0);
        chk("mid_rxcnt_end", 64'(rx_cnt), 64'd0);
        chk("mid_txcnt_end", 64'(tx_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
